// File: rtl/soc_bus_pkg.sv
// Shared types and default constants for the SoC data-bus interconnect.
package soc_bus_pkg;

  // Transaction FSM encoding (kept as plain constants for legacy tools).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Read data returned on an unmapped or timed-out read.
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Default memory map: RAM at 0x0000 (4 KiB), GPIO at 0x1000, TIMER at 0x2000.
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE  = 32'h0000_1000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] TIMER_BASE = 32'h0000_2000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;

  // Width of a slave index; at least one bit even for a single slave.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational address decoder: maps an address to a slave index.
// The lowest-numbered matching slave wins when windows overlap.
module soc_addr_decode
  import soc_bus_pkg::*;
#(
  parameter int                  N_SLV = 3,
  parameter int                  AW    = 32,
  parameter logic [N_SLV*AW-1:0] BASE  = '0,
  parameter logic [N_SLV*AW-1:0] MASK  = '0,
  parameter int                  IW    = idx_width(N_SLV)
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the highest index down so the lowest match is written last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr_i & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/soc_dbus_xbar.sv
// Data-bus interconnect: core data port to N memory-mapped slaves.
// One transaction at a time; IDLE latches, ACCESS waits for ack or timeout,
// RESP returns a single-cycle ready pulse with optional error.
module soc_dbus_xbar
  import soc_bus_pkg::*;
#(
  parameter int                  AW       = 32,
  parameter int                  DW       = 32,
  parameter int                  N_SLV    = 3,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = {TIMER_BASE, GPIO_BASE, RAM_BASE},
  parameter logic [N_SLV*AW-1:0] SLV_MASK = {TIMER_MASK, GPIO_MASK, RAM_MASK},
  parameter int                  TIMEOUT  = 16,
  parameter logic [DW-1:0]       ERR_DATA = ERR_DATA_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dm_rd_req_i,
  input  logic [AW-1:0]       dm_rd_addr_i,
  input  logic                dm_wr_req_i,
  input  logic [AW-1:0]       dm_wr_addr_i,
  input  logic [DW-1:0]       dm_wr_data_i,
  output logic [DW-1:0]       dm_rd_data_o,
  output logic                dm_ready_o,
  output logic                dm_err_o,
  output logic [N_SLV-1:0]    s_wen_o,
  output logic [N_SLV-1:0]    s_ren_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_wdata_o,
  input  logic [N_SLV*DW-1:0] s_rdata_i,
  input  logic [N_SLV-1:0]    s_ack_i
);

  localparam int IW = idx_width(N_SLV);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic [N_SLV-1:0]  wen_q, wen_d;
  logic [N_SLV-1:0]  ren_q, ren_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic              req_any;
  logic [AW-1:0]     req_addr;
  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [N_SLV-1:0]  dec_onehot;
  logic              ack_sel;
  logic [DW-1:0]     rdata_sel;

  // Write wins over a simultaneous read; the held read is taken next time round.
  assign req_any  = dm_wr_req_i | dm_rd_req_i;
  assign req_addr = dm_wr_req_i ? dm_wr_addr_i : dm_rd_addr_i;

  soc_addr_decode #(
    .N_SLV (N_SLV),
    .AW    (AW),
    .BASE  (SLV_BASE),
    .MASK  (SLV_MASK),
    .IW    (IW)
  ) u_addr_decode (
    .addr_i (req_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // Expand decoded index to a one-hot enable pattern.
  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < N_SLV; i++) begin
      dec_onehot[i] = (dec_idx == IW'(i));
    end
  end

  // Pick ack and read data of the latched slave only; other acks are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q == IW'(i)) begin
        ack_sel   = s_ack_i[i];
        rdata_sel = s_rdata_i[i*DW +: DW];
      end
    end
  end

  // Next-state and datapath for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    sel_d     = sel_q;
    err_d     = err_q;
    rd_data_d = rd_data_q;
    wen_d     = wen_q;
    ren_d     = ren_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (req_any) begin
          op_wr_d = dm_wr_req_i;
          addr_d  = req_addr;
          wdata_d = dm_wr_data_i;
          sel_d   = dec_idx;
          cnt_d   = '0;
          if (dec_hit) begin
            wen_d   = dm_wr_req_i ? dec_onehot : '0;
            ren_d   = dm_wr_req_i ? '0 : dec_onehot;
            state_d = ST_ACCESS;
          end else begin
            err_d     = 1'b1;
            rd_data_d = dm_wr_req_i ? '0 : ERR_DATA;
            state_d   = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (ack_sel) begin
          err_d     = 1'b0;
          rd_data_d = op_wr_q ? '0 : rdata_sel;
          wen_d     = '0;
          ren_d     = '0;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d     = 1'b1;
          rd_data_d = op_wr_q ? '0 : ERR_DATA;
          wen_d     = '0;
          ren_d     = '0;
          state_d   = ST_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        wen_d   = '0;
        ren_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops slave enables immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_wr_q   <= 1'b0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      wen_q     <= '0;
      ren_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_wr_q   <= op_wr_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign dm_ready_o   = (state_q == ST_RESP);
  assign dm_err_o     = dm_ready_o & err_q;
  assign dm_rd_data_o = rd_data_q;
  assign s_wen_o      = wen_q;
  assign s_ren_o      = ren_q;
  assign s_addr_o     = addr_q;
  assign s_wdata_o    = wdata_q;

endmodule

// File: tb/tb_soc_dbus_xbar.sv
// Scoreboard bench for soc_dbus_xbar: stimulus pushes expected responses,
// a negedge monitor pops and compares each dm_ready_o pulse.
module tb_soc_dbus_xbar;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_rd_req_i;
  logic [31:0] dm_rd_addr_i;
  logic        dm_wr_req_i;
  logic [31:0] dm_wr_addr_i;
  logic [31:0] dm_wr_data_i;
  logic [31:0] dm_rd_data_o;
  logic        dm_ready_o;
  logic        dm_err_o;
  logic [2:0]  s_wen_o;
  logic [2:0]  s_ren_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [95:0] s_rdata_i;
  logic [2:0]  s_ack_i;

  soc_dbus_xbar dut (
    .clk          (clk),
    .rst          (rst),
    .dm_rd_req_i  (dm_rd_req_i),
    .dm_rd_addr_i (dm_rd_addr_i),
    .dm_wr_req_i  (dm_wr_req_i),
    .dm_wr_addr_i (dm_wr_addr_i),
    .dm_wr_data_i (dm_wr_data_i),
    .dm_rd_data_o (dm_rd_data_o),
    .dm_ready_o   (dm_ready_o),
    .dm_err_o     (dm_err_o),
    .s_wen_o      (s_wen_o),
    .s_ren_o      (s_ren_o),
    .s_addr_o     (s_addr_o),
    .s_wdata_o    (s_wdata_o),
    .s_rdata_i    (s_rdata_i),
    .s_ack_i      (s_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  // Slave models: per-slave wait count before ack (255 = never acks).
  int          wait_cfg[3];
  int          wcnt[3];
  int          wen_cnt[3];
  int          ren_cnt[3];
  logic [31:0] slv_data[3];
  logic [2:0]  model_ack = '0;
  logic [2:0]  late_mask = '0;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;

  assign s_rdata_i = {slv_data[2], slv_data[1], slv_data[0]};
  assign s_ack_i   = model_ack | late_mask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave behaviour, enable bookkeeping and one-hot check.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (s_wen_o[i] || s_ren_o[i]) begin
        model_ack[i] = (wcnt[i] == wait_cfg[i]);
        wcnt[i]++;
        if (s_wen_o[i]) wen_cnt[i]++;
        if (s_ren_o[i]) ren_cnt[i]++;
        last_addr  = s_addr_o;
        last_wdata = s_wdata_o;
      end else begin
        model_ack[i] = 1'b0;
        wcnt[i]      = 0;
      end
    end
    if (!rst) chk("en_onehot", 32'($onehot0(s_wen_o | s_ren_o)), 32'd1);
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dm_ready_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("resp%0d_err", e.tag), 32'(dm_err_o), 32'(e.err));
          chk($sformatf("resp%0d_data", e.tag), dm_rd_data_o, e.data);
          chk($sformatf("resp%0d_cycle", e.tag), 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("err_outside_resp", 32'(dm_err_o), 32'd0);
      end
    end
  end

  task automatic clr_cnt();
    for (int i = 0; i < 3; i++) begin
      wen_cnt[i] = 0;
      ren_cnt[i] = 0;
    end
  endtask

  task automatic push(input logic err, input logic [31:0] data, input int lat, input int tag);
    exp_t e;
    e.err  = err;
    e.data = data;
    e.cyc  = cyc + lat;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // One core transaction; called in an IDLE cycle just after a negedge.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_data, input int lat,
                       input int tag, input bit mangle);
    bit got = 0;
    push(exp_err, exp_data, lat, tag);
    if (wr) begin
      dm_wr_req_i  = 1'b1;
      dm_wr_addr_i = addr;
      dm_wr_data_i = wdata;
    end else begin
      dm_rd_req_i  = 1'b1;
      dm_rd_addr_i = addr;
    end
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (mangle && n == 1) begin
        dm_rd_addr_i = 32'h0000_2000;
        dm_wr_addr_i = 32'h0000_2000;
        dm_wr_data_i = 32'hFFFF_FFFF;
      end
      if (dm_ready_o) got = 1;
    end
    if (!got) begin
      chk($sformatf("resp%0d_timeout", tag), 32'd0, 32'd1);
      sb.delete();
    end
    dm_wr_req_i = 1'b0;
    dm_rd_req_i = 1'b0;
    repeat (1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=hung want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nready;
    rst          = 1'b1;
    dm_rd_req_i  = 1'b0;
    dm_rd_addr_i = '0;
    dm_wr_req_i  = 1'b0;
    dm_wr_addr_i = '0;
    dm_wr_data_i = '0;
    for (int i = 0; i < 3; i++) begin
      wait_cfg[i] = 0;
      wcnt[i]     = 0;
      slv_data[i] = '0;
    end
    clr_cnt();

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(dm_ready_o), 32'd0);
    chk("rst_err",   32'(dm_err_o), 32'd0);
    chk("rst_rdata", dm_rd_data_o, 32'd0);
    chk("rst_wen",   32'(s_wen_o), 32'd0);
    chk("rst_ren",   32'(s_ren_o), 32'd0);
    chk("rst_addr",  s_addr_o, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write to RAM, 0-wait slave
    clr_cnt();
    issue(1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0, 2, 1, 0);
    chk("w1_wen0_cycles", 32'(wen_cnt[0]), 32'd1);
    chk("w1_other_en", 32'(wen_cnt[1] + wen_cnt[2] + ren_cnt[0] + ren_cnt[1] + ren_cnt[2]), 32'd0);
    chk("w1_addr",  last_addr, 32'h0000_0010);
    chk("w1_wdata", last_wdata, 32'h1234_5678);

    // 2: read GPIO, 4 wait cycles, address changed mid-transaction
    clr_cnt();
    wait_cfg[1] = 4;
    slv_data[1] = 32'hA5A5_0001;
    issue(0, 32'h0000_1004, 32'h0, 1'b0, 32'hA5A5_0001, 6, 2, 1);
    chk("r2_ren1_cycles", 32'(ren_cnt[1]), 32'd5);
    chk("r2_ren2_cycles", 32'(ren_cnt[2]), 32'd0);
    chk("r2_addr", last_addr, 32'h0000_1004);
    wait_cfg[1] = 0;

    // 3: unmapped read, unmapped write
    clr_cnt();
    issue(0, 32'h0000_8000, 32'h0, 1'b1, 32'hDEAD_BEEF, 1, 3, 0);
    issue(1, 32'h0000_3000, 32'h5555_AAAA, 1'b1, 32'h0, 1, 4, 0);
    chk("unmapped_no_en", 32'(wen_cnt[0] + wen_cnt[1] + wen_cnt[2] + ren_cnt[0] + ren_cnt[1] + ren_cnt[2]), 32'd0);

    // 4: timer never acks; foreign acks ignored, late ack ignored
    clr_cnt();
    wait_cfg[2] = 255;
    slv_data[2] = 32'h7777_7777;
    late_mask   = 3'b011;
    issue(0, 32'h0000_2004, 32'h0, 1'b1, 32'hDEAD_BEEF, 17, 5, 0);
    late_mask   = 3'b000;
    chk("to_ren2_cycles", 32'(ren_cnt[2]), 32'd16);
    chk("to_ren2_low", 32'(s_ren_o), 32'd0);
    late_mask = 3'b100;
    repeat (5) @(negedge clk);
    late_mask = 3'b000;
    repeat (2) @(negedge clk);
    chk("to_no_extra_ready", 32'(sb.size()), 32'd0);

    // 5: simultaneous write (RAM) and read (GPIO): write first
    clr_cnt();
    slv_data[1] = 32'h5A5A_0003;
    push(1'b0, 32'h0, 2, 6);
    push(1'b0, 32'h5A5A_0003, 5, 7);
    dm_wr_req_i  = 1'b1;
    dm_wr_addr_i = 32'h0000_0020;
    dm_wr_data_i = 32'hCAFE_0002;
    dm_rd_req_i  = 1'b1;
    dm_rd_addr_i = 32'h0000_1008;
    nready = 0;
    for (int n = 0; n < 40 && nready < 2; n++) begin
      @(negedge clk);
      if (dm_ready_o) begin
        nready++;
        if (nready == 1) dm_wr_req_i = 1'b0;
        else             dm_rd_req_i = 1'b0;
      end
    end
    dm_wr_req_i = 1'b0;
    dm_rd_req_i = 1'b0;
    chk("both_ready_count", 32'(nready), 32'd2);
    if (nready < 2) sb.delete();
    chk("both_wen0", 32'(wen_cnt[0]), 32'd1);
    chk("both_ren1", 32'(ren_cnt[1]), 32'd1);
    repeat (2) @(negedge clk);

    // 6: reset during ACCESS, then a normal read
    clr_cnt();
    dm_rd_req_i  = 1'b1;
    dm_rd_addr_i = 32'h0000_2010;
    repeat (3) @(negedge clk);
    chk("rst_mid_ren_before", 32'(s_ren_o), 32'b100);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ren_after", 32'(s_ren_o), 32'd0);
    chk("rst_mid_wen_after", 32'(s_wen_o), 32'd0);
    chk("rst_mid_ready", 32'(dm_ready_o), 32'd0);
    dm_rd_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_resp", 32'(sb.size()), 32'd0);
    wait_cfg[0] = 2;
    slv_data[0] = 32'h0BAD_F00D;
    issue(0, 32'h0000_0040, 32'h0, 1'b0, 32'h0BAD_F00D, 4, 8, 0);
    chk("post_rst_ren0", 32'(ren_cnt[0]), 32'd3);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
